// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial sequence transmitter.
//   tx_state_e   : 2-bit FSM state encoding (ST_IDLE, ST_PREAMBLE, ST_SHIFT, ST_GAP)
//   SYNC_PATTERN : "100" sync preamble, sent MSB first
//   SYNC_LEN     : number of preamble bits
//   clamp_len()  : maps a requested frame length onto 1..max_len
package seq_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_GAP      = 2'd3
    } tx_state_e;

    localparam logic [2:0]  SYNC_PATTERN = 3'b100;
    localparam int unsigned SYNC_LEN     = 3;

    // Zero or oversize lengths mean "send the whole word".
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return ((len == 0) || (len > max_len)) ? max_len : len;
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-load, shift-left register with MSB tap.
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high; clears the register
//   load_i      : capture load_data_i (has priority over shift_i)
//   load_data_i : parallel word
//   shift_i     : shift left by one, zero fill
//   msb_o       : current MSB
module tx_shift_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              shift_i,
    output logic              msb_o
);

    logic [DATA_W-1:0] shreg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= load_data_i;
        end else if (shift_i) begin
            shreg_q <= shreg_q << 1;
        end
    end

    assign msb_o = shreg_q[DATA_W-1];

endmodule

// File: rtl/serial_seq_transmitter.sv
// Serial transmitter: takes a word over valid/ready and sends its top load_len bits
// MSB first on serial_out, one bit per clock, followed by GAP_CYCLES idle-low cycles.
// Optional feature macro SEQ_TX_PREAMBLE_EN: prefix every frame with the "100" sync
// preamble so a downstream "100" analyzer flags the frame start.
//   clk, reset  : clock (rising edge), asynchronous active-high reset
//   load_valid  : load_data/load_len valid
//   load_ready  : high only in IDLE; transfer on load_valid && load_ready
//   load_data   : frame bits, MSB sent first
//   load_len    : bits to send; 0 or >DATA_W sends DATA_W bits
//   serial_out  : registered serial line, idles at 0
//   busy        : frame in progress
//   frame_done  : one-cycle pulse on the return to IDLE after a completed frame
module serial_seq_transmitter
    import seq_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [DATA_W-1:0]            load_data,
    input  logic [$clog2(DATA_W+1)-1:0]  load_len,
    output logic                         serial_out,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int unsigned LenW = $clog2(DATA_W + 1);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_e         state_q;
    logic              serial_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic [LenW-1:0]   bits_left_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic [LenW-1:0]   len_clamped;
    logic [DATA_W-1:0] shreg_load_val;
    logic              shreg_load;
    logic              shreg_shift;
    logic              shreg_msb;

`ifdef SEQ_TX_PREAMBLE_EN
    localparam logic [1:0] SyncLast = 2'(SYNC_LEN - 1);
    localparam logic [1:0] SyncEnd  = 2'(SYNC_LEN);
    logic [1:0] pre_cnt_q;

    // The first data bit leaves from the register after the preamble, so load unshifted.
    assign shreg_load_val = load_data;
    assign shreg_shift    = ((state_q == ST_SHIFT) && (bits_left_q != LenW'(1))) ||
                            ((state_q == ST_PREAMBLE) && (pre_cnt_q == SyncEnd));
`else
    // The first data bit goes straight to serial_out on the transfer edge, so the
    // register starts one position ahead.
    assign shreg_load_val = load_data << 1;
    assign shreg_shift    = (state_q == ST_SHIFT) && (bits_left_q != LenW'(1));
`endif

    assign len_clamped = LenW'(clamp_len(32'(load_len), DATA_W));
    assign shreg_load  = (state_q == ST_IDLE) && load_valid;

    tx_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .clk         (clk),
        .reset       (reset),
        .load_i      (shreg_load),
        .load_data_i (shreg_load_val),
        .shift_i     (shreg_shift),
        .msb_o       (shreg_msb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            serial_q    <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bits_left_q <= '0;
            gap_cnt_q   <= '0;
`ifdef SEQ_TX_PREAMBLE_EN
            pre_cnt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        bits_left_q <= len_clamped;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b0;
`ifdef SEQ_TX_PREAMBLE_EN
                        state_q     <= ST_PREAMBLE;
                        pre_cnt_q   <= 2'd1;
                        serial_q    <= SYNC_PATTERN[SyncLast];
`else
                        state_q     <= ST_SHIFT;
                        serial_q    <= load_data[DATA_W-1];
`endif
                    end else begin
                        serial_q <= 1'b0;
                    end
                end
`ifdef SEQ_TX_PREAMBLE_EN
                ST_PREAMBLE: begin
                    if (pre_cnt_q == SyncEnd) begin
                        state_q  <= ST_SHIFT;
                        serial_q <= shreg_msb;
                    end else begin
                        serial_q  <= SYNC_PATTERN[SyncLast - pre_cnt_q];
                        pre_cnt_q <= pre_cnt_q + 2'd1;
                    end
                end
`endif
                ST_SHIFT: begin
                    // bits_left counts the bit currently on the line.
                    if (bits_left_q == LenW'(1)) begin
                        serial_q <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= GapW'(GAP_CYCLES - 1);
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        serial_q    <= shreg_msb;
                        bits_left_q <= bits_left_q - LenW'(1);
                    end
                end
                ST_GAP: begin
                    serial_q <= 1'b0;
                    if (gap_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GapW'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    serial_q <= 1'b0;
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign serial_out = serial_q;
    assign load_ready = ready_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_serial_seq_transmitter.sv
// Scoreboard bench for serial_seq_transmitter: instance a uses GAP_CYCLES=2, instance b
// GAP_CYCLES=0. The driver pushes the expected per-cycle {serial_out,busy,frame_done,
// load_ready} for each accepted frame; a monitor pops one entry per active DUT cycle.
module tb_serial_seq_transmitter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       lv_a = 1'b0, lv_b = 1'b0;
    logic [7:0] ld_a = '0,   ld_b = '0;
    logic [3:0] ll_a = '0,   ll_b = '0;
    logic       rdy_a, so_a, busy_a, done_a;
    logic       rdy_b, so_b, busy_b, done_b;

    logic [3:0] q_a[$];
    logic [3:0] q_b[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_seq_transmitter #(.DATA_W(8), .GAP_CYCLES(2)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .load_valid (lv_a),
        .load_ready (rdy_a),
        .load_data  (ld_a),
        .load_len   (ll_a),
        .serial_out (so_a),
        .busy       (busy_a),
        .frame_done (done_a)
    );

    serial_seq_transmitter #(.DATA_W(8), .GAP_CYCLES(0)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .load_valid (lv_b),
        .load_ready (rdy_b),
        .load_data  (ld_b),
        .load_len   (ll_b),
        .serial_out (so_b),
        .busy       (busy_b),
        .frame_done (done_b)
    );

`ifdef SEQ_TX_PREAMBLE_EN
    // Downstream "100" analyzer model fed by instance a.
    logic [2:0] hist;
    logic       det;
    always @(posedge clk or posedge reset) begin
        if (reset) hist <= 3'b000;
        else       hist <= {hist[1:0], so_a};
    end
    assign det = (hist == 3'b100);
`endif

    task automatic push_item(input int sel, input logic [3:0] item);
        if (sel == 0) q_a.push_back(item);
        else          q_b.push_back(item);
    endtask

    // Items are {serial_out, busy, frame_done, load_ready}.
    task automatic push_frame(input int sel, input logic [7:0] d, input logic [3:0] len,
                              input int gap);
        int l;
        l = ((len == 0) || (len > 8)) ? 8 : int'(len);
`ifdef SEQ_TX_PREAMBLE_EN
        push_item(sel, 4'b1100);
        push_item(sel, 4'b0100);
        push_item(sel, 4'b0100);
`endif
        for (int i = 0; i < l; i++) push_item(sel, {d[7-i], 3'b100});
        for (int g = 0; g < gap; g++) push_item(sel, 4'b0100);
        push_item(sel, 4'b0011);
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic [3:0] len,
                        input bit keep, input bit b2b);
        int n;
        @(negedge clk);
        if (sel == 0) begin lv_a = 1'b1; ld_a = d; ll_a = len; end
        else          begin lv_b = 1'b1; ld_b = d; ll_b = len; end
        n = 0;
        while (((sel == 0) ? rdy_a : rdy_b) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send%0d_timeout: load_ready stayed low, required high within 200", sel);
        end
        if (b2b) begin
            checks++;
            if (((sel == 0) ? done_a : done_b) !== 1'b1) begin
                errors++;
                $display("FAIL b2b_on_done%0d: frame_done=%b at second transfer, required 1",
                         sel, (sel == 0) ? done_a : done_b);
            end
        end
        push_frame(sel, d, len, (sel == 0) ? 2 : 0);
        @(posedge clk);
        #1;
        if (!keep) begin
            if (sel == 0) lv_a = 1'b0;
            else          lv_b = 1'b0;
        end
    endtask

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        while (((sel == 0) ? q_a.size() : q_b.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL idle%0d_timeout: %0d expected cycles left, required 0", sel,
                     (sel == 0) ? q_a.size() : q_b.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic mon_step(input int sel, input logic [3:0] act);
        logic [3:0] exp;
        checks++;
        if (act[2] || act[1]) begin
            if (((sel == 0) ? q_a.size() : q_b.size()) == 0) begin
                errors++;
                $display("FAIL mon%0d_unexpected: so/busy/done/rdy=%b, required no activity",
                         sel, act);
            end else begin
                if (sel == 0) exp = q_a.pop_front();
                else          exp = q_b.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL mon%0d_cycle: so/busy/done/rdy=%b, required %b",
                             sel, act, exp);
                end
            end
        end else if ({act[3], act[0]} !== 2'b01) begin
            errors++;
            $display("FAIL mon%0d_idle: so/rdy=%b%b, required 01", sel, act[3], act[0]);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon_step(0, {so_a, busy_a, done_a, rdy_a});
            mon_step(1, {so_b, busy_b, done_b, rdy_b});
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checks++;
        if ({so_a, busy_a, done_a, rdy_a, so_b, busy_b, done_b, rdy_b} !== 8'b0001_0001) begin
            errors++;
            $display("FAIL reset_state: a=%b b=%b, required 0001 0001",
                     {so_a, busy_a, done_a, rdy_a}, {so_b, busy_b, done_b, rdy_b});
        end
        #2 reset = 1'b0;

        // Plain frame, GAP=2: frame_done lands in the 11th cycle after transfer.
        send(0, 8'hA5, 4'd8, 1'b0, 1'b0);
        wait_idle(0);

        // Short and clamped lengths.
        send(0, 8'b1100_0000, 4'd2, 1'b0, 1'b0);
        wait_idle(0);
        send(0, 8'h3C, 4'd0, 1'b0, 1'b0);
        wait_idle(0);
        send(0, 8'h96, 4'd9, 1'b0, 1'b0);
        wait_idle(0);

        // Back-to-back with load_valid held.
        send(0, 8'hFF, 4'd8, 1'b1, 1'b0);
        send(0, 8'h00, 4'd8, 1'b0, 1'b1);
        wait_idle(0);

        // One-bit frame; with the preamble the analyzer fires after the third sync bit.
        send(0, 8'h80, 4'd1, 1'b0, 1'b0);
`ifdef SEQ_TX_PREAMBLE_EN
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (det !== 1'b0) begin
            errors++;
            $display("FAIL analyzer_early: det=%b during third sync bit, required 0", det);
        end
        @(posedge clk);
        #1;
        checks++;
        if (det !== 1'b1) begin
            errors++;
            $display("FAIL analyzer_detect: det=%b after third sync bit, required 1", det);
        end
`endif
        wait_idle(0);

        // GAP_CYCLES=0 back-to-back frames.
        send(1, 8'hA5, 4'd8, 1'b1, 1'b0);
        send(1, 8'h5A, 4'd4, 1'b1, 1'b1);
        send(1, 8'hF0, 4'd8, 1'b0, 1'b1);
        wait_idle(1);

        // Reset in the middle of shifting 0xA5.
        send(0, 8'hA5, 4'd8, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({so_a, busy_a, done_a, rdy_a} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_midframe: so/busy/done/rdy=%b, required 0001",
                     {so_a, busy_a, done_a, rdy_a});
        end
        q_a.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (15) @(negedge clk);

        // Accepts a fresh frame after the abort.
        send(0, 8'h81, 4'd8, 1'b0, 1'b0);
        wait_idle(0);

        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: a=%0d b=%0d left, required 0 0",
                     q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
